cr16_run_ctrl: RTL
==================

Name: cr16_run_ctrl

Overview:
Run/debug sequencer for the CR16 core at top level. It replaces fixed "enable until PC limit" logic with a small FSM that drives the core's I_ENABLE and I_NRESET:
- Reset hold, free-run and single-step.
- PC breakpoint and max-PC limit.
- Halt-cause reporting and an enabled-cycle counter for the 7-segment/LED debug path.

Parameters:
P_PC_WIDTH, 16, width of PC, breakpoint and limit values.
P_RESET_CYCLES, 4, cycles O_CR16_NRESET is held low after I_RESET deasserts (≥1).
P_AUTO_RUN, 1, 1: go to RUN after reset hold; 0: go to HALT.
P_STEP_TIMEOUT, 8, max enabled cycles per single step before forced halt (≥1).

Ports:
I_CLK  in  1  system clock; all logic on posedge.
I_RESET  in  1  synchronous, active-high reset.
I_RUN  in  1  resume free-run; rising-edge detected internally.
I_STEP  in  1  single-step request; rising-edge detected internally.
I_HALT  in  1  level; halt request, highest priority after reset.
I_BREAK_EN  in  1  breakpoint enable.
I_BREAK_PC  in  P_PC_WIDTH  breakpoint address.
I_MAX_PC  in  P_PC_WIDTH  halt when I_PC ≥ this value.
I_PC  in  P_PC_WIDTH  current PC from core O_PC.
O_CR16_ENABLE  out  1  core clock-enable.
O_CR16_NRESET  out  1  core reset, active-low.
O_STATE  out  2  0 RESET, 1 HALT, 2 RUN, 3 STEP.
O_HALT_CAUSE  out  3  0 NONE, 1 USER, 2 BREAK, 3 MAX_PC, 4 STEP_DONE, 5 STEP_TIMEOUT.
O_CYCLE_COUNT  out  32  count of cycles with O_CR16_ENABLE=1.

Behaviour:
- I_RESET=1 forces the following state, overriding everything, including mid-step or mid-run:
  - state RESET; hold counter = 0.
  - O_CR16_NRESET=0, O_CR16_ENABLE=0, O_HALT_CAUSE=NONE, O_CYCLE_COUNT=0.
  - Edge-detector history = 1, so a button held through reset produces no edge.
  - skip flag = 0.
- RESET: after I_RESET falls, hold O_CR16_NRESET=0 for exactly P_RESET_CYCLES cycles. Then release (1) and move to RUN if P_AUTO_RUN, else HALT (cause NONE).
- HALT: enable=0.
  - I_STEP edge → STEP; latch step_pc=I_PC; clear step counter.
  - Else I_RUN edge with I_HALT=0 → RUN.
  - Leaving HALT: set skip=1 if I_BREAK_EN and I_PC==I_BREAK_PC. Clear cause to NONE.
- RUN: O_CR16_ENABLE is combinational:
  - stop = I_HALT | bp_hit | (I_PC ≥ I_MAX_PC), unsigned compare.
  - bp_hit = I_BREAK_EN & (I_PC==I_BREAK_PC) & !skip.
  - enable = !stop, so the core never executes a cycle at a stopping PC.
  - On stop, next state HALT. Cause priority: USER > BREAK > MAX_PC.
- skip clears on the first cycle where I_PC ≠ I_BREAK_PC. This lets a breakpoint be resumed past while multi-cycle instructions hold the PC.
- STEP: enable = !(I_HALT | I_PC ≥ I_MAX_PC); the breakpoint is ignored. Step counter increments each enabled cycle.
  - Exit to HALT when I_PC ≠ step_pc (cause STEP_DONE). The core is not enabled on that cycle.
  - Or when counter reaches P_STEP_TIMEOUT (cause STEP_TIMEOUT).
  - I_HALT → USER; max-PC → MAX_PC.
  - RUN/STEP edges are ignored while in STEP or RUN.
- Simultaneous I_RUN and I_STEP edges in HALT: STEP wins.
- O_CYCLE_COUNT saturates at 32'hFFFF_FFFF; reset only by I_RESET.
- All outputs except O_CR16_ENABLE are registered. O_CR16_ENABLE is a function of state, skip and inputs only (no input-to-output combinational loop through the core beyond O_PC).

Optional Feature:
CR16_RUN_CTRL_CYCLE_COUNT_EN:
- Defined: the 32-bit saturating counter is implemented as described.
- Undefined: no counter flops; O_CYCLE_COUNT tied to 0.

Decomposition:
- Package cr16_run_ctrl_pkg holds:
  - state enum (2-bit) and halt-cause enum (3-bit) with the encodings above;
  - localparam for counter width (32).
- One natural sub-module: cr16_run_ctrl_edge_detect, a registered rising-edge detector instantiated for I_RUN and I_STEP. Its history register is set to 1 on reset.

Test Plan:
1. Reset, P_RESET_CYCLES=4, P_AUTO_RUN=1, I_MAX_PC=16'h0008, I_PC ramps 0..8 → NRESET low 4 cycles; enable=1 for PC 0..7; enable=0 at PC=8 the same cycle; next cycle O_STATE=1, cause=3.
2. Breakpoint: I_BREAK_EN=1, I_BREAK_PC=16'h0003 → halt at PC=3 with cause=2. I_RUN pulse → enable=1 while PC stays 3 for 2 cycles; no re-halt; run continues to PC 4+.
3. Step from HALT at PC=5, core advances PC to 6 after 2 enabled cycles → exactly 2 enable cycles; HALT with cause=4; step_pc=5.
4. Step with PC stuck at 5, P_STEP_TIMEOUT=8 → exactly 8 enable cycles, then HALT, cause=5.
5. I_HALT asserted during RUN and STEP → enable=0 same cycle, cause=1. I_RESET asserted mid-step → next cycle O_STATE=0, NRESET=0, O_CYCLE_COUNT=0.
6. I_RUN held high through reset with P_AUTO_RUN=0 → stays HALT until I_RUN falls and rises again. Simultaneous I_RUN/I_STEP edges → STEP.

Source files
------------

// File: rtl/cr16_run_ctrl_pkg.sv
// cr16_run_ctrl_pkg
// Shared types for the CR16 run/debug sequencer.
//   run_state_t   : 2-bit sequencer state, encoded as reported on O_STATE.
//   halt_cause_t  : 3-bit halt reason, encoded as reported on O_HALT_CAUSE.
//   CYCLE_COUNT_WIDTH : width of the enabled-cycle counter output.
package cr16_run_ctrl_pkg;

  localparam int CYCLE_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HALT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE         = 3'd0,
    CAUSE_USER         = 3'd1,
    CAUSE_BREAK        = 3'd2,
    CAUSE_MAX_PC       = 3'd3,
    CAUSE_STEP_DONE    = 3'd4,
    CAUSE_STEP_TIMEOUT = 3'd5
  } halt_cause_t;

endpackage

// File: rtl/cr16_run_ctrl_edge_detect.sv
// cr16_run_ctrl_edge_detect
// Rising-edge detector for a level button/request input.
// Ports:
//   I_CLK   : clock, posedge
//   I_RESET : synchronous active-high reset; history is forced to 1 so a
//             level held through reset does not look like a fresh edge
//   I_SIG   : level input
//   O_RISE  : high in the cycle I_SIG is 1 while it was 0 the cycle before
module cr16_run_ctrl_edge_detect (
  input  logic I_CLK,
  input  logic I_RESET,
  input  logic I_SIG,
  output logic O_RISE
);

  logic sig_hist;

  // One cycle of history; presetting it to 1 swallows held buttons.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      sig_hist <= 1'b1;
    end else begin
      sig_hist <= I_SIG;
    end
  end

  assign O_RISE = I_SIG & ~sig_hist;

endmodule

// File: rtl/cr16_run_ctrl.sv
// cr16_run_ctrl
// Run/debug sequencer driving the CR16 core enable and reset: reset hold,
// free-run, single-step, PC breakpoint, max-PC limit, halt-cause reporting
// and an enabled-cycle counter.
// Ports:
//   I_CLK, I_RESET           : clock and synchronous active-high reset
//   I_RUN, I_STEP            : run / single-step requests (edge detected)
//   I_HALT                   : level halt request
//   I_BREAK_EN, I_BREAK_PC   : breakpoint enable and address
//   I_MAX_PC                 : halt when I_PC >= this (unsigned)
//   I_PC                     : current core PC
//   O_CR16_ENABLE            : core clock-enable (combinational)
//   O_CR16_NRESET            : core reset, active low (registered)
//   O_STATE, O_HALT_CAUSE    : sequencer state and last halt reason
//   O_CYCLE_COUNT            : saturating count of enabled cycles
// Build option: define CR16_RUN_CTRL_CYCLE_COUNT_EN to implement the cycle
// counter; otherwise O_CYCLE_COUNT is tied to zero and no flops are built.
module cr16_run_ctrl
  import cr16_run_ctrl_pkg::*;
#(
  parameter int P_PC_WIDTH     = 16,
  parameter int P_RESET_CYCLES = 4,
  parameter int P_AUTO_RUN     = 1,
  parameter int P_STEP_TIMEOUT = 8
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic                         I_RUN,
  input  logic                         I_STEP,
  input  logic                         I_HALT,
  input  logic                         I_BREAK_EN,
  input  logic [P_PC_WIDTH-1:0]        I_BREAK_PC,
  input  logic [P_PC_WIDTH-1:0]        I_MAX_PC,
  input  logic [P_PC_WIDTH-1:0]        I_PC,
  output logic                         O_CR16_ENABLE,
  output logic                         O_CR16_NRESET,
  output logic [1:0]                   O_STATE,
  output logic [2:0]                   O_HALT_CAUSE,
  output logic [CYCLE_COUNT_WIDTH-1:0] O_CYCLE_COUNT
);

  localparam int HOLD_W = (P_RESET_CYCLES > 1) ? $clog2(P_RESET_CYCLES) : 1;
  localparam int STEP_W = $clog2(P_STEP_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(P_RESET_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(P_STEP_TIMEOUT);

  run_state_t              state_q, state_d;
  halt_cause_t             cause_q, cause_d;
  logic                    nreset_q, nreset_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [STEP_W-1:0]       step_cnt_q, step_cnt_d;
  logic [P_PC_WIDTH-1:0]   step_pc_q, step_pc_d;
  logic                    skip_q, skip_d;
  logic                    enable;
  logic                    run_rise, step_rise;
  logic                    pc_at_break, pc_at_limit, bp_hit;

  cr16_run_ctrl_edge_detect u_run_edge (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .I_SIG   (I_RUN),
    .O_RISE  (run_rise)
  );

  cr16_run_ctrl_edge_detect u_step_edge (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .I_SIG   (I_STEP),
    .O_RISE  (step_rise)
  );

  assign pc_at_break = (I_PC == I_BREAK_PC);
  assign pc_at_limit = (I_PC >= I_MAX_PC);
  // skip lets a resumed run execute past the breakpoint it stopped on.
  assign bp_hit      = I_BREAK_EN & pc_at_break & ~skip_q;

  // Next-state and core-enable decode. The core is only enabled in the
  // branch where no stop condition applies, so it never executes a cycle
  // at a PC that halts the sequencer.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    nreset_d   = nreset_q;
    hold_cnt_d = hold_cnt_q;
    step_cnt_d = step_cnt_q;
    step_pc_d  = step_pc_q;
    skip_d     = skip_q & pc_at_break;
    enable     = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (hold_cnt_q == HOLD_LAST) begin
          nreset_d = 1'b1;
          state_d  = (P_AUTO_RUN != 0) ? ST_RUN : ST_HALT;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (step_rise || (run_rise && !I_HALT)) begin
          state_d    = step_rise ? ST_STEP : ST_RUN;
          step_pc_d  = I_PC;
          step_cnt_d = '0;
          skip_d     = I_BREAK_EN & pc_at_break;
          cause_d    = CAUSE_NONE;
        end
      end
      ST_RUN: begin
        if (I_HALT) begin
          state_d = ST_HALT;
          cause_d = CAUSE_USER;
        end else if (bp_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BREAK;
        end else if (pc_at_limit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_MAX_PC;
        end else begin
          enable = 1'b1;
        end
      end
      ST_STEP: begin
        if (I_HALT) begin
          state_d = ST_HALT;
          cause_d = CAUSE_USER;
        end else if (pc_at_limit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_MAX_PC;
        end else if (I_PC != step_pc_q) begin
          state_d = ST_HALT;
          cause_d = CAUSE_STEP_DONE;
        end else if (step_cnt_q == STEP_LAST) begin
          state_d = ST_HALT;
          cause_d = CAUSE_STEP_TIMEOUT;
        end else begin
          enable     = 1'b1;
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Sequencer registers; reset overrides any run or step in progress.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= ST_RESET;
      cause_q    <= CAUSE_NONE;
      nreset_q   <= 1'b0;
      hold_cnt_q <= '0;
      step_cnt_q <= '0;
      step_pc_q  <= '0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      nreset_q   <= nreset_d;
      hold_cnt_q <= hold_cnt_d;
      step_cnt_q <= step_cnt_d;
      step_pc_q  <= step_pc_d;
      skip_q     <= skip_d;
    end
  end

  // The core must not run in the cycle reset is asserted, whatever state.
  assign O_CR16_ENABLE = enable & ~I_RESET;
  assign O_CR16_NRESET = nreset_q;
  assign O_STATE       = state_q;
  assign O_HALT_CAUSE  = cause_q;

`ifdef CR16_RUN_CTRL_CYCLE_COUNT_EN
  logic [CYCLE_COUNT_WIDTH-1:0] cycle_count_q;

  // Saturating count of enabled core cycles, cleared only by reset.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cycle_count_q <= '0;
    end else if (O_CR16_ENABLE && (cycle_count_q != '1)) begin
      cycle_count_q <= cycle_count_q + 1'b1;
    end
  end

  assign O_CYCLE_COUNT = cycle_count_q;
`else
  assign O_CYCLE_COUNT = '0;
`endif

endmodule
